// File: rtl/uart_tx_frame.sv
// UART transmitter: start + DATA_BITS (LSB first) + optional parity + STOP_BITS,
// internal baud divider. Define UART_TX_PARITY_EN to insert the parity bit.
module uart_tx_frame #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_idx;
  logic                 accept;
  logic                 last_stop;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  assign accept    = tx_valid & tx_ready;
  assign last_stop = (STOP_BITS == 1) || stop_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      stop_idx <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      tx_ready <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          tx_ready <= 1'b1;
        end
        START: begin
          if (cnt == '0) begin
            state <= DATA;
            cnt   <= CNT_TOP;
            idx   <= '0;
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[DATA_BITS-1:1]};
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            cnt <= CNT_TOP;
            if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par_bit;
`else
              state    <= STOP;
              tx       <= 1'b1;
              stop_idx <= 1'b0;
`endif
            end else begin
              idx   <= idx + 1'b1;
              tx    <= shreg[0];
              shreg <= {1'b0, shreg[DATA_BITS-1:1]};
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cnt == '0) begin
            state    <= STOP;
            cnt      <= CNT_TOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == '0) begin
            if (last_stop) begin
              state    <= IDLE;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
              cnt      <= CNT_TOP;
            end
          end else begin
            cnt      <= cnt - 1'b1;
            tx_ready <= (cnt == CNT_W'(1)) && last_stop;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase

      // Accept only occurs in IDLE or on the last stop cycle; overriding here
      // starts the next frame with no idle gap after the stop bit.
      if (accept) begin
        state    <= START;
        cnt      <= CNT_TOP;
        shreg    <= tx_data;
        tx       <= 1'b0;
        busy     <= 1'b1;
        tx_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_bit  <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8N1 instance plus a 7-bit, 2-stop, odd-parity instance.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx, busy;
  logic [6:0] tx_data2;
  logic       tx_valid2, tx_ready2, tx2, busy2;

  int tests = 0;
  int fails = 0;
  logic exp_tx[$];

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy)
  );

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_bit(input logic b);
    for (int k = 0; k < 4; k++) exp_tx.push_back(b);
  endtask

  task automatic add_frame(input logic [7:0] d);
    push_bit(1'b0);
    for (int i = 0; i < 8; i++) push_bit(d[i]);
`ifdef UART_TX_PARITY_EN
    push_bit(^d);
`endif
    push_bit(1'b1);
  endtask

  task automatic kick(input logic [7:0] d);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'b0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic stream(input string tag, input int drop_at, input bit scramble,
                        input logic [7:0] d_after);
    for (int c = 0; c < exp_tx.size(); c++) begin
      chk({tag, "_tx"}, {31'b0, tx}, {31'b0, exp_tx[c]});
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      if (c == 0) tx_data = d_after;
      if (scramble && c < drop_at) tx_data = 8'($urandom);
      if (c == drop_at) tx_valid = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_idle_tx"}, {31'b0, tx}, 32'd1);
    chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_idle_ready"}, {31'b0, tx_ready}, 32'd1);
  endtask

  initial begin
    int n2, nb2;
    logic e2;
    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_valid2 = 1'b0;
    tx_data2  = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, tx_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, tx_ready}, 32'd1);
    chk("post_rst_ready2", {31'b0, tx_ready2}, 32'd1);

    // single 0x55 frame
    exp_tx.delete();
    add_frame(8'h55);
    kick(8'h55);
    stream("t1", 0, 1'b0, 8'h55);

    // back-to-back 0xA5, 0x3C with valid held
    exp_tx.delete();
    add_frame(8'hA5);
    add_frame(8'h3C);
    kick(8'hA5);
    stream("t2", 40, 1'b0, 8'h3C);

    // reset during data bit 3 of 0xF0
    kick(8'hF0);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("t3_bit3", {31'b0, tx}, 32'd0);
    chk("t3_busy_pre", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t3_rst_tx", {31'b0, tx}, 32'd1);
    chk("t3_rst_busy", {31'b0, busy}, 32'd0);
    chk("t3_rst_ready", {31'b0, tx_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t3_ready_after", {31'b0, tx_ready}, 32'd1);
    exp_tx.delete();
    add_frame(8'h81);
    kick(8'h81);
    stream("t3", 0, 1'b0, 8'h81);

    // valid held with changing data while busy
    exp_tx.delete();
    add_frame(8'h96);
    kick(8'h96);
    stream("t4", 30, 1'b1, 8'h96);
    repeat (3) begin
      @(negedge clk);
      chk("t4_no_extra", {31'b0, busy}, 32'd0);
    end

`ifdef UART_TX_PARITY_EN
    exp_tx.delete();
    add_frame(8'h07);
    kick(8'h07);
    stream("t5", 0, 1'b0, 8'h07);
`endif

    // 7 data bits, 2 stop bits on the second instance
    nb2 = 10;
`ifdef UART_TX_PARITY_EN
    nb2 = 11;
`endif
    n2 = 0;
    while (tx_ready2 !== 1'b1 && n2 < 200) begin
      @(negedge clk);
      n2++;
    end
    chk("t6_ready_wait", {31'b0, tx_ready2}, 32'd1);
    tx_data2  = 7'h7F;
    tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    for (int c = 0; c < nb2 * 4; c++) begin
      e2 = (c >= 4);
`ifdef UART_TX_PARITY_EN
      if (c >= 32 && c < 36) e2 = 1'b0;
`endif
      chk("t6_tx", {31'b0, tx2}, {31'b0, e2});
      chk("t6_busy", {31'b0, busy2}, 32'd1);
      @(negedge clk);
    end
    chk("t6_idle_tx", {31'b0, tx2}, 32'd1);
    chk("t6_idle_busy", {31'b0, busy2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
